// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction-memory, decode handshake and redirect signals of the fetch stage.
interface instruction_fetch_unit_if #(
    parameter int AW = 6,
    parameter int IW = 32
);
    logic [AW-1:0] pc_addr;
    logic [IW-1:0] instr_in;
    logic          id_ready;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          if_valid;
    logic [IW-1:0] if_instr;
    logic [AW-1:0] if_pc;

    modport master (
        output pc_addr, if_valid, if_instr, if_pc,
        input  instr_in, id_ready, branch_taken, branch_target
    );
    modport slave (
        input  pc_addr, if_valid, if_instr, if_pc,
        output instr_in, id_ready, branch_taken, branch_target
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC register and IF/ID holding register with stall, branch flush and zero-word halt.
module instruction_fetch_unit #(
    parameter int            AW           = 6,
    parameter int            IW           = 32,
    parameter logic [AW-1:0] RESET_PC     = '0,
    parameter int            HALT_ON_ZERO = 1,
    parameter int            CW           = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    instruction_fetch_unit_if.master bus,
    output logic                     halted,
    output logic [CW-1:0]            fetch_count
);
    typedef enum logic {FETCH, HALT} state_t;

    state_t        state, state_n;
    logic [AW-1:0] pc, pc_n, ipc, ipc_n;
    logic [IW-1:0] instr, instr_n;
    logic          valid, valid_n;
    logic [CW-1:0] cnt_n;
    logic          transfer, slot_free, zero_word;

    assign transfer  = valid && bus.id_ready;
    assign slot_free = !valid || bus.id_ready;
    assign zero_word = (HALT_ON_ZERO != 0) && (bus.instr_in == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            valid       <= 1'b0;
            instr       <= '0;
            ipc         <= '0;
            fetch_count <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            valid       <= valid_n;
            instr       <= instr_n;
            ipc         <= ipc_n;
            fetch_count <= cnt_n;
        end
    end

    // A redirect wins in either state; zero-word detection only happens when the slot can take a word.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        valid_n = valid;
        instr_n = instr;
        ipc_n   = ipc;
        cnt_n   = (transfer && fetch_count != '1) ? fetch_count + CW'(1) : fetch_count;
        if (bus.branch_taken) begin
            state_n = FETCH;
            pc_n    = bus.branch_target;
            valid_n = 1'b0;
        end else if (state == FETCH && slot_free) begin
            if (zero_word) begin
                state_n = HALT;
                valid_n = 1'b0;
            end else begin
                pc_n    = pc + AW'(1);
                valid_n = 1'b1;
                instr_n = bus.instr_in;
                ipc_n   = pc;
            end
        end
    end

    assign bus.pc_addr  = pc;
    assign bus.if_valid = valid;
    assign bus.if_instr = instr;
    assign bus.if_pc    = ipc;
    assign halted       = (state == HALT);
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scenarios plus randomized run against a behavioural fetch model.
module tb_instruction_fetch_unit;
    localparam int AW = 6;
    localparam int IW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          halted;
    logic [CW-1:0] fetch_count;
    logic [IW-1:0] mem [64];
    int            tests = 0;
    int            fails = 0;

    instruction_fetch_unit_if #(.AW(AW), .IW(IW)) bus ();

    instruction_fetch_unit #(
        .AW(AW), .IW(IW), .RESET_PC('0), .HALT_ON_ZERO(1), .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master),
        .halted(halted),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;
    assign bus.instr_in = mem[bus.pc_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h00200003;
        mem[1] = 32'h00200003;
        mem[2] = 32'h10640022;
        mem[3] = 32'h0;
        for (int i = 4; i < 64; i++) mem[i] = 32'hA000_0000 | i;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus.id_ready      = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        load_prog();
        apply_reset();
        tests++;
        if ({bus.pc_addr, bus.if_valid, bus.if_instr, bus.if_pc, halted, fetch_count} !==
            {6'd0, 1'b0, 32'h0, 6'd0, 1'b0, 16'd0}) begin
            fails++;
            $display("FAIL reset: pc=%0d v=%0b instr=%h ipc=%0d halt=%0b cnt=%0d, want all zero",
                     bus.pc_addr, bus.if_valid, bus.if_instr, bus.if_pc, halted, fetch_count);
        end
    endtask

    task automatic test_program();
        logic [IW-1:0] exp_i [3];
        exp_i = '{32'h00200003, 32'h00200003, 32'h10640022};
        load_prog();
        apply_reset();
        bus.id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== AW'(k) || bus.if_instr !== exp_i[k]) begin
                fails++;
                $display("FAIL program[%0d]: v=%0b pc=%0d instr=%h, want v=1 pc=%0d instr=%h",
                         k, bus.if_valid, bus.if_pc, bus.if_instr, k, exp_i[k]);
            end
        end
        tick();
        tests++;
        if (halted !== 1'b1 || bus.if_valid !== 1'b0 || bus.pc_addr !== 6'd3 || fetch_count !== 16'd3) begin
            fails++;
            $display("FAIL halt_on_zero: halted=%0b v=%0b pc=%0d cnt=%0d, want 1 0 3 3",
                     halted, bus.if_valid, bus.pc_addr, fetch_count);
        end
        bus.id_ready = 1'b0;
        tick();
        bus.id_ready = 1'b1;
        tick();
        tests++;
        if (halted !== 1'b1 || bus.pc_addr !== 6'd3 || bus.if_valid !== 1'b0) begin
            fails++;
            $display("FAIL halt_hold: halted=%0b pc=%0d v=%0b, want 1 3 0", halted, bus.pc_addr, bus.if_valid);
        end
    endtask

    task automatic test_stall();
        load_prog();
        apply_reset();
        bus.id_ready = 1'b1;
        tick();
        tick();
        bus.id_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            tests++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 6'd1 || bus.if_instr !== 32'h00200003 || bus.pc_addr !== 6'd2) begin
                fails++;
                $display("FAIL stall[%0d]: v=%0b ipc=%0d instr=%h pc=%0d, want 1 1 00200003 2",
                         k, bus.if_valid, bus.if_pc, bus.if_instr, bus.pc_addr);
            end
        end
        bus.id_ready = 1'b1;
        tick();
        tests++;
        if (bus.if_pc !== 6'd2 || bus.if_instr !== 32'h10640022 || fetch_count !== 16'd2) begin
            fails++;
            $display("FAIL stall_resume: ipc=%0d instr=%h cnt=%0d, want 2 10640022 2",
                     bus.if_pc, bus.if_instr, fetch_count);
        end
    endtask

    task automatic test_branch_flush();
        load_prog();
        apply_reset();
        bus.id_ready = 1'b1;
        tick();
        bus.id_ready      = 1'b0;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 6'd5;
        tick();
        tests++;
        if (bus.if_valid !== 1'b0 || bus.pc_addr !== 6'd5 || bus.if_pc !== 6'd0 || fetch_count !== 16'd0) begin
            fails++;
            $display("FAIL flush: v=%0b pc=%0d ipc=%0d cnt=%0d, want 0 5 0 0",
                     bus.if_valid, bus.pc_addr, bus.if_pc, fetch_count);
        end
        bus.branch_taken = 1'b0;
        bus.id_ready     = 1'b1;
        tick();
        tests++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 6'd5 || bus.if_instr !== mem[5]) begin
            fails++;
            $display("FAIL after_flush: v=%0b ipc=%0d instr=%h, want 1 5 %h",
                     bus.if_valid, bus.if_pc, bus.if_instr, mem[5]);
        end
        bus.branch_taken  = 1'b1;
        bus.branch_target = 6'd9;
        tick();
        bus.branch_taken = 1'b0;
        tests++;
        if (bus.if_valid !== 1'b0 || bus.pc_addr !== 6'd9 || fetch_count !== 16'd1) begin
            fails++;
            $display("FAIL branch_with_transfer: v=%0b pc=%0d cnt=%0d, want 0 9 1",
                     bus.if_valid, bus.pc_addr, fetch_count);
        end
    endtask

    task automatic test_wrap();
        load_prog();
        mem[63] = 32'hDEAD_BEEF;
        apply_reset();
        bus.id_ready      = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 6'd63;
        tick();
        bus.branch_taken = 1'b0;
        tick();
        tests++;
        if (bus.if_pc !== 6'd63 || bus.if_instr !== 32'hDEAD_BEEF || bus.pc_addr !== 6'd0) begin
            fails++;
            $display("FAIL wrap: ipc=%0d instr=%h pc=%0d, want 63 deadbeef 0",
                     bus.if_pc, bus.if_instr, bus.pc_addr);
        end
    endtask

    task automatic test_halt_redirect();
        load_prog();
        apply_reset();
        bus.id_ready = 1'b1;
        repeat (4) tick();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 6'd1;
        tick();
        bus.branch_taken = 1'b0;
        tests++;
        if (halted !== 1'b0 || bus.pc_addr !== 6'd1 || bus.if_valid !== 1'b0) begin
            fails++;
            $display("FAIL halt_exit: halted=%0b pc=%0d v=%0b, want 0 1 0", halted, bus.pc_addr, bus.if_valid);
        end
        tick();
        tests++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 6'd1 || bus.if_instr !== 32'h00200003) begin
            fails++;
            $display("FAIL halt_refetch: v=%0b ipc=%0d instr=%h, want 1 1 00200003",
                     bus.if_valid, bus.if_pc, bus.if_instr);
        end
    endtask

    task automatic test_async_reset();
        load_prog();
        apply_reset();
        bus.id_ready = 1'b1;
        repeat (2) tick();
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (bus.if_valid !== 1'b0 || halted !== 1'b0 || bus.pc_addr !== 6'd0 || fetch_count !== 16'd0) begin
            fails++;
            $display("FAIL async_reset: v=%0b halted=%0b pc=%0d cnt=%0d, want 0 0 0 0",
                     bus.if_valid, halted, bus.pc_addr, fetch_count);
        end
        #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [AW-1:0] m_pc, m_ipc;
        logic [IW-1:0] m_instr;
        logic          m_valid, m_halt, rdy, br;
        logic [AW-1:0] tgt;
        int            m_cnt;
        for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
        apply_reset();
        m_pc = '0; m_ipc = '0; m_instr = '0; m_valid = 1'b0; m_halt = 1'b0; m_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            rdy = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 9) == 0) || (m_halt && $urandom_range(0, 2) == 0);
            tgt = AW'($urandom);
            bus.id_ready      = rdy;
            bus.branch_taken  = br;
            bus.branch_target = tgt;
            if (m_valid && rdy && m_cnt < 65535) m_cnt++;
            if (br) begin
                m_pc = tgt; m_valid = 1'b0; m_halt = 1'b0;
            end else if (!m_halt && (!m_valid || rdy)) begin
                if (mem[m_pc] == 32'h0) begin
                    m_valid = 1'b0; m_halt = 1'b1;
                end else begin
                    m_instr = mem[m_pc]; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 1'b1;
                end
            end
            tick();
            tests++;
            if ({bus.pc_addr, bus.if_valid, halted, fetch_count} !== {m_pc, m_valid, m_halt, CW'(m_cnt)} ||
                (m_valid && {bus.if_instr, bus.if_pc} !== {m_instr, m_ipc})) begin
                fails++;
                $display("FAIL random[%0d]: pc=%0d v=%0b halt=%0b cnt=%0d ipc=%0d instr=%h, want %0d %0b %0b %0d %0d %h",
                         c, bus.pc_addr, bus.if_valid, halted, fetch_count, bus.if_pc, bus.if_instr,
                         m_pc, m_valid, m_halt, m_cnt, m_ipc, m_instr);
            end
        end
        bus.branch_taken = 1'b0;
    endtask

    initial begin
        bus.id_ready      = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        test_reset();
        test_program();
        test_stall();
        test_branch_flush();
        test_wrap();
        test_halt_redirect();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
